// File: rtl/axi_pkg.sv
// Shared AXI constants, FSM state types and burst legality helper for the
// DRAM responder.
package axi_pkg;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [2:0] SIZE_4B     = 3'b010;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
   typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rd_state_t;

   function automatic logic burst_legal(input logic [2:0] size, input logic [1:0] burst);
      return (size == SIZE_4B) && (burst == BURST_INCR);
   endfunction
endpackage

// File: rtl/axi_mem_core.sv
// Word-addressed storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module axi_mem_core #(
   parameter int MEM_AW     = 12,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [MEM_AW-1:0]     waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [MEM_AW-1:0]     raddr,
   output logic [DATA_WIDTH-1:0] rdata
);
   logic [DATA_WIDTH-1:0] mem [2**MEM_AW];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];
endmodule

// File: rtl/axi4_dram_responder.sv
// AXI4 responder backing 16-beat INCR bursts with an internal memory; read and
// write channels run independently, one outstanding burst each.
module axi4_dram_responder
   import axi_pkg::*;
#(
   parameter int ID_WIDTH   = 4,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int MEM_AW     = 12,
   parameter int RD_LAT     = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ID_WIDTH-1:0]   arid_s_inf,
   input  logic [ADDR_WIDTH-1:0] araddr_s_inf,
   input  logic [3:0]            arlen_s_inf,
   input  logic [2:0]            arsize_s_inf,
   input  logic [1:0]            arburst_s_inf,
   input  logic                  arvalid_s_inf,
   output logic                  arready_s_inf,
   output logic [ID_WIDTH-1:0]   rid_s_inf,
   output logic [DATA_WIDTH-1:0] rdata_s_inf,
   output logic [1:0]            rresp_s_inf,
   output logic                  rlast_s_inf,
   output logic                  rvalid_s_inf,
   input  logic                  rready_s_inf,
   input  logic [ID_WIDTH-1:0]   awid_s_inf,
   input  logic [ADDR_WIDTH-1:0] awaddr_s_inf,
   input  logic [2:0]            awsize_s_inf,
   input  logic [1:0]            awburst_s_inf,
   input  logic [3:0]            awlen_s_inf,
   input  logic                  awvalid_s_inf,
   output logic                  awready_s_inf,
   input  logic [DATA_WIDTH-1:0] wdata_s_inf,
   input  logic                  wlast_s_inf,
   input  logic                  wvalid_s_inf,
   output logic                  wready_s_inf,
   output logic [ID_WIDTH-1:0]   bid_s_inf,
   output logic [1:0]            bresp_s_inf,
   output logic                  bvalid_s_inf,
   input  logic                  bready_s_inf
);
   localparam logic [3:0] LAT_END = 4'(RD_LAT - 2);

   wr_state_t             w_state, w_next;
   logic [ID_WIDTH-1:0]   w_id;
   logic [MEM_AW-1:0]     w_idx;
   logic [3:0]            w_len;
   logic                  w_legal, w_err, w_in_range, mem_we;
   logic [4:0]            w_cnt;
   logic [1:0]            b_resp;

   rd_state_t             r_state, r_next;
   logic [ID_WIDTH-1:0]   r_id;
   logic [MEM_AW-1:0]     r_idx, ar_idx, rd_addr;
   logic [3:0]            r_len, r_beat, lat_cnt;
   logic                  r_legal, ar_legal, ld, ld_legal;
   logic [DATA_WIDTH-1:0] rdata_q, mem_rdata;
   logic [1:0]            r_resp;

   logic unused_addr_bits;
   assign unused_addr_bits = ^{araddr_s_inf[ADDR_WIDTH-1:MEM_AW+2], araddr_s_inf[1:0],
                               awaddr_s_inf[ADDR_WIDTH-1:MEM_AW+2], awaddr_s_inf[1:0]};

   axi_mem_core #(.MEM_AW(MEM_AW), .DATA_WIDTH(DATA_WIDTH)) u_mem (
      .clk   (clk),
      .we    (mem_we),
      .waddr (w_idx),
      .wdata (wdata_s_inf),
      .raddr (rd_addr),
      .rdata (mem_rdata)
   );

   // ---------------- write channel ----------------
   assign w_in_range = (w_cnt <= {1'b0, w_len});

   always_comb begin
      w_next        = w_state;
      awready_s_inf = 1'b0;
      wready_s_inf  = 1'b0;
      bvalid_s_inf  = 1'b0;
      mem_we        = 1'b0;
      case (w_state)
         W_IDLE: begin
            awready_s_inf = 1'b1;
            if (awvalid_s_inf) w_next = W_DATA;
         end
         W_DATA: begin
            wready_s_inf = 1'b1;
            if (wvalid_s_inf) begin
               mem_we = w_legal && w_in_range;
               if (wlast_s_inf) w_next = W_RESP;
            end
         end
         W_RESP: begin
            bvalid_s_inf = 1'b1;
            if (bready_s_inf) w_next = W_IDLE;
         end
         default: w_next = W_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w_state <= W_IDLE;
         w_id    <= '0;
         w_idx   <= '0;
         w_len   <= '0;
         w_legal <= 1'b0;
         w_cnt   <= '0;
         w_err   <= 1'b0;
         b_resp  <= RESP_OKAY;
      end else begin
         w_state <= w_next;
         if (w_state == W_IDLE && awvalid_s_inf) begin
            w_id    <= awid_s_inf;
            w_idx   <= awaddr_s_inf[MEM_AW+1:2];
            w_len   <= awlen_s_inf;
            w_legal <= burst_legal(awsize_s_inf, awburst_s_inf);
            w_cnt   <= '0;
            w_err   <= 1'b0;
         end
         if (w_state == W_DATA && wvalid_s_inf) begin
            w_idx <= w_idx + MEM_AW'(1);
            // Count saturates at 16 so overrun beats never fall back in range.
            if (!w_cnt[4]) w_cnt <= w_cnt + 5'd1;
            if (!w_in_range) w_err <= 1'b1;
            if (wlast_s_inf)
               b_resp <= (!w_legal || w_err || (w_cnt != {1'b0, w_len})) ? RESP_SLVERR : RESP_OKAY;
         end
      end
   end

   assign bid_s_inf   = w_id;
   assign bresp_s_inf = b_resp;

   // ---------------- read channel ----------------
   assign ar_idx   = araddr_s_inf[MEM_AW+1:2];
   assign ar_legal = burst_legal(arsize_s_inf, arburst_s_inf);

   // Beat data is registered as it is fetched, so it stays stable under
   // backpressure and a same-edge write to that word yields the old value.
   always_comb begin
      r_next        = r_state;
      arready_s_inf = 1'b0;
      rvalid_s_inf  = 1'b0;
      ld            = 1'b0;
      rd_addr       = r_idx;
      ld_legal      = r_legal;
      case (r_state)
         R_IDLE: begin
            arready_s_inf = 1'b1;
            rd_addr       = ar_idx;
            ld_legal      = ar_legal;
            if (arvalid_s_inf) begin
               r_next = (RD_LAT == 1) ? R_DATA : R_WAIT;
               ld     = (RD_LAT == 1);
            end
         end
         R_WAIT: begin
            if (lat_cnt == LAT_END) begin
               r_next = R_DATA;
               ld     = 1'b1;
            end
         end
         R_DATA: begin
            rvalid_s_inf = 1'b1;
            rd_addr      = r_idx + MEM_AW'(1);
            if (rready_s_inf) begin
               if (r_beat == r_len) r_next = R_IDLE;
               else                 ld     = 1'b1;
            end
         end
         default: r_next = R_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= R_IDLE;
         r_id    <= '0;
         r_idx   <= '0;
         r_len   <= '0;
         r_legal <= 1'b0;
         r_beat  <= '0;
         lat_cnt <= '0;
         rdata_q <= '0;
         r_resp  <= RESP_OKAY;
      end else begin
         r_state <= r_next;
         if (ld) rdata_q <= ld_legal ? mem_rdata : '0;
         case (r_state)
            R_IDLE: if (arvalid_s_inf) begin
               r_id    <= arid_s_inf;
               r_idx   <= ar_idx;
               r_len   <= arlen_s_inf;
               r_legal <= ar_legal;
               r_resp  <= ar_legal ? RESP_OKAY : RESP_SLVERR;
               r_beat  <= '0;
               lat_cnt <= '0;
            end
            R_WAIT: lat_cnt <= lat_cnt + 4'd1;
            R_DATA: if (rready_s_inf && (r_beat != r_len)) begin
               r_idx  <= r_idx + MEM_AW'(1);
               r_beat <= r_beat + 4'd1;
            end
            default: ;
         endcase
      end
   end

   assign rid_s_inf   = r_id;
   assign rdata_s_inf = rdata_q;
   assign rresp_s_inf = r_resp;
   assign rlast_s_inf = (r_state == R_DATA) && (r_beat == r_len);
endmodule
